// File: rtl/bus_pkg.sv
// Shared Sysbus responder definitions: tag layout, line geometry, FSM states and
// the byte-address to line-base helper.
package bus_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_TAG_WIDTH  = 13;
  localparam int unsigned TAG_WRITE_BIT  = DEF_TAG_WIDTH - 1;
  localparam int unsigned DEF_LINE_BEATS = 8;
  localparam int unsigned WORD_OFFSET    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } responder_state_t;

  // Word index wrapped to the array depth, then aligned down to a line boundary.
  function automatic logic [31:0] line_base(input logic [31:0] word_idx,
                                            input int unsigned mem_words,
                                            input int unsigned line_beats);
    logic [31:0] wrapped;
    wrapped = word_idx & (mem_words - 1);
    return wrapped & ~(line_beats - 1);
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Sysbus request/response signals between a cache initiator (master) and the
// memory-side responder (slave).
interface bus_responder_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
) ();

  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

endinterface

// File: rtl/bus_mem_array.sv
// Word memory with bus and backdoor write ports (bus wins) and a registered read port.
// Latency: read data valid the cycle after rd_en; reads return pre-edge contents.
// Backpressure: none; caller holds rd_en low to freeze rd_data.
module bus_mem_array #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned WORDS      = 4096,
  parameter int unsigned ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_we,
  input  logic [ADDR_WIDTH-1:0] bus_waddr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bd_we,
  input  logic [ADDR_WIDTH-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_data,
  input  logic                  rd_en,
  input  logic                  rd_clr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Storage is never reset; the later bus write overrides a same-word backdoor write.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
    if (bus_we) begin
      mem[bus_waddr] <= bus_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-side Sysbus end: captures line requests, absorbs write lines, returns read lines.
// Latency: ack 1 cycle after accept; first read beat READ_LATENCY+1 cycles after capture.
// Backpressure: response beats hold until bus_respack; requests are ignored while busy.
module bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUS_TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int unsigned LINE_BEATS     = DEF_LINE_BEATS,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned READ_LATENCY   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  bus_responder_if.slave               bus,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [BUS_DATA_WIDTH-1:0]    bd_data
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned BW = $clog2(LINE_BEATS);
  localparam int unsigned CW = $clog2(READ_LATENCY + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [CW-1:0] LAT_DONE  = CW'(READ_LATENCY);

  responder_state_t         state, state_nx;
  logic [BW-1:0]            beat, beat_nx;
  logic [CW-1:0]            lat_cnt, lat_cnt_nx;
  logic [AW-1:0]            base, base_nx;
  logic [BUS_TAG_WIDTH-1:0] tag, tag_nx;
  logic                     reqack_nx;
  logic                     respcyc_nx;
  logic                     mem_we;
  logic                     rd_en;
  logic                     rd_clr;
  logic [AW-1:0]            wr_addr;
  logic [AW-1:0]            rd_addr;
  logic [BUS_DATA_WIDTH-1:0] rd_data;

  assign wr_addr = base + AW'(beat);

  always_comb begin
    state_nx   = state;
    beat_nx    = beat;
    lat_cnt_nx = lat_cnt;
    base_nx    = base;
    tag_nx     = tag;
    reqack_nx  = 1'b0;
    respcyc_nx = bus.bus_respcyc;
    mem_we     = 1'b0;
    rd_en      = 1'b0;
    rd_clr     = 1'b0;
    rd_addr    = base;
    case (state)
      IDLE: begin
        if (bus.bus_reqcyc) begin
          base_nx    = AW'(line_base(32'(bus.bus_req[WORD_OFFSET +: AW]), MEM_WORDS, LINE_BEATS));
          tag_nx     = bus.bus_reqtag;
          reqack_nx  = 1'b1;
          beat_nx    = '0;
          lat_cnt_nx = '0;
          state_nx   = bus.bus_reqtag[BUS_TAG_WIDTH-1] ? WDATA : RWAIT;
        end
      end
      WDATA: begin
        if (bus.bus_reqcyc) begin
          mem_we    = 1'b1;
          reqack_nx = 1'b1;
          if (beat == LAST_BEAT) begin
            beat_nx  = '0;
            state_nx = IDLE;
          end else begin
            beat_nx = beat + 1'b1;
          end
        end
      end
      RWAIT: begin
        if (lat_cnt == LAT_DONE) begin
          rd_en      = 1'b1;
          respcyc_nx = 1'b1;
          state_nx   = RESP;
        end else begin
          lat_cnt_nx = lat_cnt + 1'b1;
        end
      end
      RESP: begin
        if (bus.bus_respack) begin
          if (beat == LAST_BEAT) begin
            rd_clr     = 1'b1;
            respcyc_nx = 1'b0;
            beat_nx    = '0;
            state_nx   = IDLE;
          end else begin
            // Fetch the next word on the same edge that retires the current beat.
            rd_en   = 1'b1;
            beat_nx = beat + 1'b1;
            rd_addr = base + AW'(beat_nx);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      beat            <= '0;
      lat_cnt         <= '0;
      base            <= '0;
      tag             <= '0;
      bus.bus_reqack  <= 1'b0;
      bus.bus_respcyc <= 1'b0;
      bus.bus_resptag <= '0;
    end else begin
      state           <= state_nx;
      beat            <= beat_nx;
      lat_cnt         <= lat_cnt_nx;
      base            <= base_nx;
      tag             <= tag_nx;
      bus.bus_reqack  <= reqack_nx;
      bus.bus_respcyc <= respcyc_nx;
      bus.bus_resptag <= tag_nx;
    end
  end

  assign bus.bus_resp = rd_data;

  bus_mem_array #(
    .DATA_WIDTH (BUS_DATA_WIDTH),
    .WORDS      (MEM_WORDS),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk       (clk),
    .reset     (reset),
    .bus_we    (mem_we),
    .bus_waddr (wr_addr),
    .bus_wdata (bus.bus_req),
    .bd_we     (bd_we),
    .bd_addr   (bd_addr),
    .bd_data   (bd_data),
    .rd_en     (rd_en),
    .rd_clr    (rd_clr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_bus_responder.sv
// Directed plus randomized transactions against a word-array model of the responder.
module tb_bus_responder;

  localparam int unsigned DW  = 64;
  localparam int unsigned TW  = 13;
  localparam int unsigned MW  = 4096;
  localparam int unsigned LAT = 4;
  localparam int unsigned NB  = 8;
  localparam int unsigned AW  = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  bus_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus_if ();

  bus_responder #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .LINE_BEATS     (NB),
    .MEM_WORDS      (MW),
    .READ_LATENCY   (LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_data (bd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [DW-1:0] model [MW];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Memory word holding beat 'beat' of the line containing byte address 'addr'.
  function automatic int word_of(input logic [63:0] addr, input int beat);
    int w;
    w = int'((addr >> 3) % MW);
    return ((w / NB) * NB + beat) % MW;
  endfunction

  task automatic issue(input logic [63:0] addr, input logic [TW-1:0] tag);
    bus_if.bus_reqcyc = 1'b1;
    bus_if.bus_req    = addr;
    bus_if.bus_reqtag = tag;
  endtask

  task automatic wait_ack(output int cap);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.bus_reqack === 1'b1) seen = 1'b1;
    end
    cap = cyc;
    bus_if.bus_reqcyc = 1'b0;
    chk("req_ack_seen", 64'(seen), 64'd1);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [TW-1:0] tag, input bit fixed,
                          input int gap_beat, input int gap_len, input int bd_beat);
    int cap;
    int acks;
    logic [63:0] d;
    issue(addr, tag);
    wait_ack(cap);
    acks = 1;
    for (int b = 0; b < NB; b++) begin
      d = fixed ? 64'h11 * 64'(b + 1) : {$urandom, $urandom};
      bus_if.bus_req    = d;
      bus_if.bus_reqcyc = 1'b1;
      if (b == bd_beat) begin
        bd_we   = 1'b1;
        bd_addr = AW'(word_of(addr, b));
        bd_data = ~d;
      end
      @(negedge clk);
      bd_we = 1'b0;
      model[word_of(addr, b)] = d;
      if (bus_if.bus_reqack === 1'b1) acks++;
      chk("wr_beat_ack", 64'(bus_if.bus_reqack), 64'd1);
      if (b == gap_beat) begin
        bus_if.bus_reqcyc = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          chk("wr_gap_no_ack", 64'(bus_if.bus_reqack), 64'd0);
        end
      end
    end
    bus_if.bus_reqcyc = 1'b0;
    @(negedge clk);
    chk("wr_done_no_ack", 64'(bus_if.bus_reqack), 64'd0);
    chk("wr_no_resp", 64'(bus_if.bus_respcyc), 64'd0);
    chk("wr_ack_count", 64'(acks), 64'(NB + 1));
  endtask

  task automatic collect(input logic [63:0] addr, input logic [TW-1:0] tag, input int cap,
                         input int stall_beat, input int stall_len, input bit chain,
                         input logic [63:0] nxt_addr, input logic [TW-1:0] nxt_tag,
                         output int end_cyc);
    bit seen;
    logic [63:0] exp;
    seen = 1'b0;
    @(negedge clk);
    chk("rd_ack_one_cycle", 64'(bus_if.bus_reqack), 64'd0);
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus_if.bus_respcyc === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rd_resp_seen", 64'(seen), 64'd1);
    chk("rd_latency", 64'(cyc - cap), 64'(LAT + 1));
    for (int b = 0; b < NB; b++) begin
      if (chain && b == 1) issue(nxt_addr, nxt_tag);
      exp = model[word_of(addr, b)];
      chk("rd_data", bus_if.bus_resp, exp);
      chk("rd_tag", 64'(bus_if.bus_resptag), 64'(tag));
      chk("rd_cyc", 64'(bus_if.bus_respcyc), 64'd1);
      if (chain) chk("busy_no_ack", 64'(bus_if.bus_reqack), 64'd0);
      if (b == stall_beat) begin
        bus_if.bus_respack = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_hold", bus_if.bus_resp, exp);
        end
      end
      bus_if.bus_respack = 1'b1;
      @(negedge clk);
    end
    bus_if.bus_respack = 1'b0;
    end_cyc = cyc;
    chk("rd_end_cyc", 64'(bus_if.bus_respcyc), 64'd0);
    chk("rd_end_resp", bus_if.bus_resp, 64'd0);
    chk("rd_end_no_ack", 64'(bus_if.bus_reqack), 64'd0);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [TW-1:0] tag,
                         input int stall_beat, input int stall_len);
    int cap;
    int end_cyc;
    issue(addr, tag);
    wait_ack(cap);
    collect(addr, tag, cap, stall_beat, stall_len, 1'b0, 64'd0, '0, end_cyc);
  endtask

  initial begin
    int cap;
    int rel;
    int end_cyc;
    int op;
    bit seen;
    logic [63:0] a;

    bus_if.bus_reqcyc  = 1'b0;
    bus_if.bus_req     = '0;
    bus_if.bus_reqtag  = '0;
    bus_if.bus_respack = 1'b0;

    // Reset held with a request pending; the backdoor preloads the array meanwhile.
    #1 reset = 1'b0;
    issue(64'h200, 13'h00A5);
    @(negedge clk);
    for (int i = 0; i < int'(MW); i++) begin
      bd_we   = 1'b1;
      bd_addr = AW'(i);
      bd_data = (i >= 64 && i < 72) ? 64'(32'h40 + i - 64) : {$urandom, $urandom};
      model[i] = bd_data;
      @(negedge clk);
    end
    bd_we = 1'b0;
    chk("reset_reqack", 64'(bus_if.bus_reqack), 64'd0);
    chk("reset_respcyc", 64'(bus_if.bus_respcyc), 64'd0);
    chk("reset_resp", bus_if.bus_resp, 64'd0);
    chk("reset_resptag", 64'(bus_if.bus_resptag), 64'd0);

    reset = 1'b1;
    rel = cyc;
    wait_ack(cap);
    chk("reset_first_capture", 64'(cap - rel), 64'd1);
    collect(64'h200, 13'h00A5, cap, -1, 0, 1'b0, 64'd0, '0, end_cyc);

    // Write with a gap after beat 2 and a colliding backdoor write on beat 5, then read back.
    do_write(64'h1008, 13'h1003, 1'b1, 2, 2, 5);
    do_read(64'h1000, 13'h00B1, -1, 0);

    // Response stall on beat 3 plus a request arriving while busy.
    issue(64'h200, 13'h00C3);
    wait_ack(cap);
    collect(64'h200, 13'h00C3, cap, 3, 5, 1'b1, 64'((MW - 4) * 8), 13'h0077, end_cyc);
    wait_ack(cap);
    chk("busy_capture_edge", 64'(cap - end_cyc), 64'd1);
    collect(64'((MW - 4) * 8), 13'h0077, cap, -1, 0, 1'b0, 64'd0, '0, end_cyc);

    // Address beyond the array depth wraps back into it.
    do_read(64'(MW * 8 + 8'h48), 13'h0123, 6, 2);

    // Asynchronous reset in the middle of a response.
    issue(64'h1000, 13'h00D2);
    wait_ack(cap);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.bus_respcyc === 1'b1) seen = 1'b1;
    end
    chk("arst_resp_seen", 64'(seen), 64'd1);
    bus_if.bus_respack = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.bus_respack = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_respcyc", 64'(bus_if.bus_respcyc), 64'd0);
    chk("arst_resp", bus_if.bus_resp, 64'd0);
    chk("arst_resptag", 64'(bus_if.bus_resptag), 64'd0);
    chk("arst_reqack", 64'(bus_if.bus_reqack), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_read(64'h1000, 13'h00D3, -1, 0);

    // Randomized mix of reads, writes and stray backdoor updates.
    for (int t = 0; t < 16; t++) begin
      op = int'($urandom_range(0, 2));
      a  = {$urandom, $urandom};
      if (op == 0) begin
        do_write(a, {1'b1, 12'($urandom)}, 1'b0, int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 10)));
      end else begin
        do_read(a, {1'b0, 12'($urandom)}, int'($urandom_range(0, 9)),
                int'($urandom_range(0, 4)));
      end
      bd_we   = 1'b1;
      bd_addr = AW'($urandom);
      bd_data = {$urandom, $urandom};
      model[bd_addr] = bd_data;
      @(negedge clk);
      bd_we = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
